// File: rtl/crypto1_subkey_gen.sv
// rtl/crypto1_subkey_gen.sv - Crypto1 half-state candidate enumerator with filter match and show-ahead subkey FIFO
module crypto1_subkey_gen #(
    parameter logic [3:0]  IDX        = 4'h0,
    parameter int          FIFO_DEPTH = 16,
    // final counter value issued; 20'hFFFFF covers the whole subspace
    parameter logic [19:0] C_LAST     = 20'hFFFFF
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [4:0]  BITSTREAM,
    input  logic        SUBKEY_RDEN,
    output logic [23:0] SUBKEY_RDDATA,
    output logic        SUBKEY_RDEMPTY,
    output logic        DONE
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] LUT_A = 16'hF22C;
    localparam logic [15:0] LUT_B = 16'hD938;
    localparam logic [31:0] LUT_F = 32'hEC57E80A;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t          state, state_nxt;
    logic [4:0]      bits_q;
    logic [19:0]     c;
    logic            issue;
    logic            s1_valid, s2_valid, s2_match;
    logic [23:0]     s1_cand, s2_cand;
    logic [4:0]      win_ok;
    logic [23:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     fifo_count;
    logic [AW+1:0]   occupancy;
    logic            push, pop;

    function automatic logic filt(input logic [19:0] x);
        logic [4:0] t;
        t = {LUT_A[x[3:0]], LUT_B[x[7:4]], LUT_A[x[11:8]], LUT_A[x[15:12]], LUT_B[x[19:16]]};
        return LUT_F[t];
    endfunction

    // Counting every in-flight stage keeps the FIFO from ever overflowing.
    always_comb begin
        occupancy = (AW+2)'(fifo_count) + (AW+2)'(s1_valid) + (AW+2)'(s2_valid);
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:  state_nxt = RUN;
            RUN: begin
                issue = occupancy < (AW+2)'(FIFO_DEPTH);
                if (issue && c == C_LAST) state_nxt = DRAIN;
            end
            DRAIN: if (!s1_valid && !s2_valid) state_nxt = FIN;
            FIN:   state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        win_ok = '0;
        for (int k = 0; k < 5; k++) begin
            win_ok[k] = filt(s1_cand[k +: 20]) == bits_q[k];
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            bits_q   <= '0;
            c        <= '0;
            s1_valid <= 1'b0;
            s1_cand  <= '0;
            s2_valid <= 1'b0;
            s2_match <= 1'b0;
            s2_cand  <= '0;
        end else begin
            if (state == IDLE) bits_q <= BITSTREAM;
            if (issue && c != C_LAST) c <= c + 20'd1;
            s1_valid <= issue;
            s1_cand  <= {IDX, c};
            s2_valid <= s1_valid;
            s2_match <= &win_ok;
            s2_cand  <= s1_cand;
        end
    end

    assign push = s2_valid & s2_match;
    assign pop  = SUBKEY_RDEN & (fifo_count != '0);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= s2_cand;
    end

    assign SUBKEY_RDEMPTY = (fifo_count == '0);
    assign SUBKEY_RDDATA  = SUBKEY_RDEMPTY ? 24'h000000 : mem[rd_ptr];
    assign DONE           = (state == FIN);
endmodule

// File: doc/crypto1_subkey_gen.md
Name: crypto1_subkey_gen

Overview:
- Producer side of the Crypto1Core subkey stream.
- Enumerates every 24-bit half-state candidate whose top nibble equals IDX (a 1/16 subspace) and filters each against a 5-bit keystream fragment using the Crypto1 filter function.
- Matching candidates go into an internal show-ahead FIFO, which the core drains through the SUBKEY_RDEN / SUBKEY_RDDATA / SUBKEY_RDEMPTY read interface.

Parameters:
- IDX, 4'h0, fixed top nibble of every candidate; candidate = {IDX, c[19:0]}.
- FIFO_DEPTH, 16, matched-subkey FIFO entries; power of two, >= 4.

Ports:
- CLK  in  1  clock.
- RESETn  in  1  asynchronous active-low reset.
- BITSTREAM  in  5  keystream bits; bit k is the expected filter output at window k.
- SUBKEY_RDEN  in  1  pop the FIFO head; ignored while SUBKEY_RDEMPTY=1.
- SUBKEY_RDDATA  out  24  FIFO head (show-ahead); valid whenever SUBKEY_RDEMPTY=0.
- SUBKEY_RDEMPTY  out  1  FIFO empty.
- DONE  out  1  sticky; all 2^20 candidates evaluated and pipeline drained.

Behaviour:
- Reset values (async):
  - SUBKEY_RDEMPTY=1, SUBKEY_RDDATA=0, DONE=0.
  - Counter c=0, FIFO pointers/count=0, state=IDLE.
- Filter f(x[19:0]):
  - n_i = x[4i+3:4i].
  - t4 = bit n0 of 16'hF22C; t3 = bit n1 of 16'hD938; t2 = bit n2 of 16'hF22C; t1 = bit n3 of 16'hF22C; t0 = bit n4 of 16'hD938.
  - f = bit {t4,t3,t2,t1,t0} of 32'hEC57E80A.
- Match rule: cand matches iff f(cand[k+19:k]) == BITSTREAM[k] for all k = 0..4.
- States:
  - IDLE: one cycle after reset release; latch BITSTREAM into an internal register, then go to RUN. Later BITSTREAM changes are ignored until the next reset.
  - RUN: issue one candidate per cycle when the issue condition holds, else stall (c held).
    - Issue condition: fifo_count + inflight < FIFO_DEPTH, where inflight = valid pipeline stages.
    - Go to DRAIN after issuing c=20'hFFFFF.
  - DRAIN: no issue; wait until the pipeline is empty, then go to FIN.
  - FIN: DONE=1 until reset. FIFO keeps serving reads.
- Pipeline:
  - Stage 1 registers cand and valid.
  - Stage 2 registers the match result.
  - Matching entries are written to the FIFO on the next edge.
  - A candidate issued in cycle N is visible on SUBKEY_RDDATA, with SUBKEY_RDEMPTY=0, no later than cycle N+3 if the FIFO was empty.
- Ordering: candidates are pushed in increasing c order; no drops, no duplicates.
- FIFO:
  - A simultaneous push and pop while full or empty is legal; count is unchanged when both occur in the same cycle.
  - Never overflows, guaranteed by the issue condition.
  - Popping while empty has no effect.
- Counter: 20 bits, no wrap. It never increments past 20'hFFFFF.
- Reset mid-operation: all state is discarded immediately, including FIFO contents and DONE. After release the block restarts from IDLE with c=0.
- Consumer contract: the enumeration is complete and all results consumed when DONE=1 and SUBKEY_RDEMPTY=1.

Test Plan:
- IDX=0, BITSTREAM=5'b00000, RDEN tied high -> first SUBKEY_RDDATA = 24'h000000 within 4 cycles after IDLE. Total pops equal the bench model count. DONE rises within 2^20+6 cycles of reset release.
- IDX=4'hF, BITSTREAM=5'b11111, RDEN high -> last popped subkey = 24'hFFFFFF. All pops in increasing order and equal to the model list.
- IDX=0, BITSTREAM=5'b00110, RDEN held low -> FIFO fills to FIFO_DEPTH and counter stalls. Release RDEN -> no lost or duplicated entries versus the model.
- Random RDEN (50%), BITSTREAM toggled every cycle after IDLE -> results match the model for the latched value. RDEN while empty causes no underflow.
- Assert RESETn mid-RUN with a non-empty FIFO -> next cycle SUBKEY_RDEMPTY=1, DONE=0. After release the enumeration restarts at c=0 and matches the model.
- After DONE=1, FIFO still holding entries -> DONE stays 1 while RDEN drains the FIFO; SUBKEY_RDEMPTY goes 1 after the last pop.
